// File: rtl/wbq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbq_pkg
// Description : Shared constants, entry type and helper for the register-file
//               writeback queue. Holds the register-file geometry, the two
//               protected register numbers (L0 and PC), the queued-entry type
//               and is_protected(), which identifies those registers.
// Revision    : 1.0 - initial release
// ============================================================================
package wbq_pkg;

    localparam int REG_W    = 19;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_L0 = 5'd0;
    localparam logic [ADDR_W-1:0] REG_PC = 5'd19;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

    // Writes to L0 and PC are never allowed to reach the register file.
    function automatic logic is_protected(input logic [ADDR_W-1:0] rd);
        return (rd == REG_L0) || (rd == REG_PC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wbq_fifo
// Description : Dual-push, single-pop circular buffer of wb_entry_t.
//               push_a/din_a : older entry, written at the write pointer
//               push_b/din_b : younger entry, written one slot later
//                              (push_b is only asserted together with push_a)
//               pop          : retire the head entry (ignored when empty)
//               head         : oldest queued entry
//               occ          : number of queued entries (0..DEPTH)
//               empty        : occ == 0
//               clk/reset    : clock, synchronous active-low reset
// Revision    : 1.0 - initial release
// ============================================================================
module wbq_fifo
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_a,
    input  wb_entry_t        din_a,
    input  logic             push_b,
    input  wb_entry_t        din_b,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] occ,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;

    logic             w_pop;
    logic [CNT_W-1:0] w_push_cnt;
    logic [PTR_W-1:0] w_wr_ptr_b;

    assign w_pop      = pop && (r_occ != '0);
    assign w_push_cnt = CNT_W'(push_a) + CNT_W'(push_b);
    assign w_wr_ptr_b = r_wr_ptr + PTR_W'(1);

    // Storage needs no reset: only slots covered by occ are ever observed.
    always_ff @(posedge clk) begin
        if (push_a) begin
            r_mem[r_wr_ptr] <= din_a;
        end
        if (push_b) begin
            r_mem[w_wr_ptr_b] <= din_b;
        end
    end

    // Pointer arithmetic truncates to PTR_W bits, which is the modulo-DEPTH
    // wrap because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_occ    <= r_occ + w_push_cnt - CNT_W'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign occ   = r_occ;
    assign empty = (r_occ == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Writer-side front end of the 32 x 19-bit register file.
//               Accepts ALU and memory-load writeback results over valid/ready,
//               drops writes to L0 (#0) and PC (#19), queues the rest in order
//               (mem older than ALU on a same-cycle pair) and drains one entry
//               per cycle onto a3/we3/wd3. pend_mask flags registers that still
//               have queued writes.
// Ports       : clk, reset (sync, active-low)
//               mem_valid/mem_rd/mem_data/mem_ready : memory-load producer
//               alu_valid/alu_rd/alu_data/alu_ready : ALU producer
//               we3/a3/wd3                          : register-file write port
//               pend_mask                           : pending-write scoreboard
//               empty                               : queue empty
//               drop_cnt/stall_cnt                  : only with WBQ_STATS_EN
// Options     : `define WBQ_STATS_EN adds saturating drop and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [REG_W-1:0]    mem_data,
    output logic                mem_ready,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [REG_W-1:0]    alu_data,
    output logic                alu_ready,
    output logic                we3,
    output logic [ADDR_W-1:0]   a3,
    output logic [REG_W-1:0]    wd3,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                empty
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_MEM_OCC_MAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_ALU_OCC_MAX = CNT_W'(DEPTH - 2);

    wb_entry_t        w_mem_entry;
    wb_entry_t        w_alu_entry;
    wb_entry_t        w_din_a;
    wb_entry_t        w_head;
    logic             w_mem_xfer;
    logic             w_alu_xfer;
    logic             w_mem_push;
    logic             w_alu_push;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop;
    logic [CNT_W-1:0] w_occ;
    logic             w_fifo_empty;
    logic [NUM_REGS-1:0] w_pend;

    assign w_mem_entry = '{rd: mem_rd, data: mem_data};
    assign w_alu_entry = '{rd: alu_rd, data: alu_data};

    // Ready is a function of registered occupancy only, so a same-cycle pop
    // earns no credit. The ALU needs one more free slot than memory because
    // memory takes the first slot when both arrive together.
    assign mem_ready = reset && (w_occ <= c_MEM_OCC_MAX);
    assign alu_ready = reset && (w_occ <= c_ALU_OCC_MAX);

    assign w_mem_xfer = mem_valid && mem_ready;
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_mem_push = w_mem_xfer && !is_protected(mem_rd);
    assign w_alu_push = w_alu_xfer && !is_protected(alu_rd);

    // Compact the surviving pushes: slot A gets the older entry, so a lone
    // ALU push lands at the write pointer without leaving a hole.
    assign w_push_a = w_mem_push || w_alu_push;
    assign w_push_b = w_mem_push && w_alu_push;
    assign w_din_a  = w_mem_push ? w_mem_entry : w_alu_entry;

    // The register file always accepts, so the head retires every cycle.
    assign w_pop = !w_fifo_empty;

    wbq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_a (w_push_a),
        .din_a  (w_din_a),
        .push_b (w_push_b),
        .din_b  (w_alu_entry),
        .pop    (w_pop),
        .head   (w_head),
        .occ    (w_occ),
        .empty  (w_fifo_empty)
    );

    assign we3   = reset && !w_fifo_empty;
    assign a3    = we3 ? w_head.rd   : '0;
    assign wd3   = we3 ? w_head.data : '0;
    assign empty = !reset || w_fifo_empty;

    // Pending-write scoreboard: one counter per writable register. Protected
    // registers can never be enqueued, so they carry no counter at all.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        if ((r == int'(REG_L0)) || (r == int'(REG_PC))) begin : g_prot
            assign w_pend[r] = 1'b0;
        end else begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc_a;
            logic             w_inc_b;
            logic             w_dec;

            assign w_inc_a = w_push_a && (w_din_a.rd == ADDR_W'(r));
            assign w_inc_b = w_push_b && (w_alu_entry.rd == ADDR_W'(r));
            assign w_dec   = w_pop && (w_head.rd == ADDR_W'(r));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(w_inc_a) + CNT_W'(w_inc_b)
                                   - CNT_W'(w_dec);
                end
            end

            assign w_pend[r] = (r_cnt != '0);
        end
    end

    assign pend_mask = reset ? w_pend : '0;

`ifdef WBQ_STATS_EN
    logic        w_mem_drop;
    logic        w_alu_drop;
    logic        w_stall;
    logic [16:0] w_drop_sum;
    logic [16:0] w_stall_sum;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_stall_cnt;

    assign w_mem_drop  = w_mem_xfer && is_protected(mem_rd);
    assign w_alu_drop  = w_alu_xfer && is_protected(alu_rd);
    assign w_stall     = (mem_valid && !mem_ready) || (alu_valid && !alu_ready);
    assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_mem_drop) + 17'(w_alu_drop);
    assign w_stall_sum = {1'b0, r_stall_cnt} + 17'(w_stall);

    // A carry out of bit 15 means the count would wrap; pin it at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_drop_cnt  <= w_drop_sum[16]  ? 16'hFFFF : w_drop_sum[15:0];
            r_stall_cnt <= w_stall_sum[16] ? 16'hFFFF : w_stall_sum[15:0];
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side front end for the 32-entry, 19-bit register file.
- Accepts writeback results from two producers, the ALU and memory-load paths, over valid/ready handshakes.
- Buffers them in order in a small FIFO and drains one entry per cycle onto the register-file write port (a3/we3/wd3).
- Drops writes to the protected registers L0 (#0) and PC (#19) at the input.
- Exports a pending-write scoreboard so the hazard logic can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1): width of the per-register pending counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; 0 clears all state.
- mem_valid  in  1  memory-load result valid.
- mem_rd  in  5  destination register number.
- mem_data  in  19  load result.
- mem_ready  out  1  queue accepts a memory result this cycle.
- alu_valid  in  1  ALU result valid.
- alu_rd  in  5  destination register number.
- alu_data  in  19  ALU result.
- alu_ready  out  1  queue accepts an ALU result this cycle.
- we3  out  1  register-file write enable.
- a3  out  5  register-file write address.
- wd3  out  19  register-file write data.
- pend_mask  out  32  bit r = 1 while at least one write to register r is queued.
- empty  out  1  FIFO empty.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - Sampled reset==0 at an edge clears FIFO pointers, the occupancy count and all pending counters.
  - While reset==0: mem_ready=0, alu_ready=0, we3=0, a3=0, wd3=0, pend_mask=0, empty=1.
  - Reset mid-drain discards all queued entries; nothing is written after reset deasserts until new results arrive.
- Ready rules depend only on the registered occupancy (occ), never on the valids:
  - mem_ready = (occ <= DEPTH-1).
  - alu_ready = (occ <= DEPTH-2).
  - A pop in the same cycle gives no credit.
- Transfers: a transfer occurs when valid&ready at a rising edge.
- Drop rule: a transfer with rd==5'd0 or rd==5'd19 completes the handshake but is not enqueued and does not touch pend_mask.
- Ordering: when both producers transfer in the same cycle, the mem entry is older.
  - The mem entry goes to slot wr_ptr and the ALU entry to wr_ptr+1.
  - Occupancy grows by the number of non-dropped transfers (0..2).
- Drain (register file always accepts):
  - we3 = !empty; a3/wd3 = head entry (0 when empty).
  - Head is popped at every edge where empty==0.
  - Latency: a result accepted at edge N drives we3 during cycle N..N+1 and is written to the register file at edge N+1, if it is the head.
  - Sustained rate is one write per cycle.
- Occupancy: occ_next = occ + pushes − pop. Pointers wrap modulo DEPTH. Overflow and underflow are impossible by construction; the bench asserts this.
- Scoreboard: one CNT_W counter per register, cnt[r].
  - Increments per enqueued entry with rd==r (+2 if both same-cycle pushes target r).
  - Decrements when the popped head has rd==r.
  - Push and pop of the same r in one cycle net out.
  - pend_mask[r] = (cnt[r]!=0). pend_mask[0] and pend_mask[19] are always 0.
- Same register queued twice: both writes drain in order; the last-enqueued value is final.

Optional Feature:
- Macro: WBQ_STATS_EN.
- Defined: adds outputs drop_cnt[15:0] and stall_cnt[15:0], both saturating at 16'hFFFF and cleared by reset.
  - drop_cnt counts dropped transfers (+2 if both producers are dropped in one cycle).
  - stall_cnt counts cycles with (mem_valid&!mem_ready) | (alu_valid&!alu_ready).
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Decomposition:
- Package wbq_pkg holds:
  - REG_W=19, ADDR_W=5, NUM_REGS=32.
  - REG_L0=5'd0, REG_PC=5'd19.
  - Typedef wb_entry_t, a packed struct of rd[4:0] and data[18:0].
  - Function is_protected(rd).
- Sub-module wbq_fifo: a dual-push, single-pop circular buffer of wb_entry_t that exposes occ, head and empty.
- The top level holds the ready logic, drop filtering, scoreboard and optional stats.

Test Plan:
- Reset, then a single ALU push rd=3, data=19'h1ABCD → the following cycle shows we3=1, a3=3, wd3=19'h1ABCD and pend_mask[3]=1; after the next edge, empty=1 and pend_mask=0.
- Same-cycle pushes mem rd=5, data=0x00011 and alu rd=5, data=0x00022 → drains 0x00011 then 0x00022 on consecutive cycles; pend_mask[5] stays 1 for two cycles, then 0.
- Pushes to rd=0 and rd=19 → both handshakes complete, we3 never asserts, pend_mask stays 0; with WBQ_STATS_EN, drop_cnt=2.
- Both producers valid every cycle with DEPTH=4 → alu_ready drops at occ=3 and mem_ready at occ=4; no entry is lost; the write sequence matches enqueue order; stall_cnt increments on each stalled cycle.
- Fill 3 entries (rd=1,2,3), then pull reset low for one edge → all outputs are 0 on the next cycle, empty=1, and no writes to 1/2/3 occur afterwards.
- Simultaneous push rd=7 and pop of the head with rd=7 → cnt[7] unchanged and pend_mask[7] stays 1 until the last rd=7 entry drains.
